// File: rtl/div_unit.sv
// Iterative 32-bit radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Define DIV_FAST_SPECIAL_EN to finish divide-by-zero and overflow early.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        kill,
    input  logic [1:0]  div_op,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIN  = 2'd2;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [1:0]  op_q;
    logic        neg_q_f;
    logic        neg_r_f;

    logic        is_signed;
    logic        accept;
    logic [31:0] mag1;
    logic [31:0] mag2;
    logic        neg_q_in;
    logic        neg_r_in;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic        ge;
    logic [31:0] q_fin;
    logic [31:0] r_fin;

    assign is_signed = ~div_op[0];
    assign accept    = (state == IDLE) && start && !kill;
    assign busy      = (state != IDLE);

    assign mag1 = (is_signed && operand1[31]) ? (~operand1 + 32'd1) : operand1;
    assign mag2 = (is_signed && operand2[31]) ? (~operand2 + 32'd1) : operand2;

    // a zero divisor keeps the all-ones quotient unsigned
    assign neg_q_in = is_signed && (operand1[31] ^ operand2[31]) && (operand2 != 32'd0);
    assign neg_r_in = is_signed && operand1[31];

    assign shifted = {rem_q, quo_q[31]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign ge      = (shifted >= {1'b0, dvs_q});

    assign q_fin = neg_q_f ? (~quo_q + 32'd1) : quo_q;
    assign r_fin = neg_r_f ? (~rem_q + 32'd1) : rem_q;

`ifdef DIV_FAST_SPECIAL_EN
    logic is_zero;
    logic is_ovf;
    assign is_zero = (operand2 == 32'd0);
    assign is_ovf  = is_signed && (operand1 == 32'h8000_0000)
                     && (operand2 == 32'hFFFF_FFFF);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 5'd0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            dvs_q   <= 32'd0;
            op_q    <= 2'd0;
            neg_q_f <= 1'b0;
            neg_r_f <= 1'b0;
            done    <= 1'b0;
            result  <= 32'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q    <= div_op;
                        neg_q_f <= neg_q_in;
                        neg_r_f <= neg_r_in;
                        dvs_q   <= mag2;
                        cnt     <= 5'd0;
`ifdef DIV_FAST_SPECIAL_EN
                        // preload the magnitudes the full loop would produce
                        if (is_zero) begin
                            quo_q <= 32'hFFFF_FFFF;
                            rem_q <= mag1;
                            state <= FIN;
                        end else if (is_ovf) begin
                            quo_q <= 32'h8000_0000;
                            rem_q <= 32'd0;
                            state <= FIN;
                        end else begin
                            quo_q <= mag1;
                            rem_q <= 32'd0;
                            state <= CALC;
                        end
`else
                        quo_q <= mag1;
                        rem_q <= 32'd0;
                        state <= CALC;
`endif
                    end
                end
                CALC: begin
                    if (kill) begin
                        state <= IDLE;
                    end else begin
                        rem_q <= ge ? diff[31:0] : shifted[31:0];
                        quo_q <= {quo_q[30:0], ge};
                        cnt   <= cnt + 5'd1;
                        if (cnt == 5'd31)
                            state <= FIN;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    if (!kill) begin
                        done   <= 1'b1;
                        result <= op_q[1] ? r_fin : q_fin;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Randomized self-checking bench for div_unit against an arithmetic model.
// Honours DIV_FAST_SPECIAL_EN for the expected latency.
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        kill;
    logic [1:0]  div_op;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          checks;
    int          failures;
    logic [31:0] prev_result;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    div_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .kill     (kill),
        .div_op   (div_op),
        .operand1 (operand1),
        .operand2 (operand2),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_div(input logic [1:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        case (op)
            OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REMU: return (b == 0) ? a : a % b;
            OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return 32'h8000_0000;
                return 32'(sa / sb);
            end
            default: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    return 32'd0;
                return 32'(sa % sb);
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        bit special;
        special = (b == 0) || (!op[0] && a == 32'h8000_0000
                               && b == 32'hFFFF_FFFF);
`ifdef DIV_FAST_SPECIAL_EN
        return special ? 2 : 34;
`else
        return special ? 34 : 34;
`endif
    endfunction

    // Accepting edge counts as edge 1; returns with done sampled high.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit glitch);
        logic [31:0] exp_r;
        int          exp_lat;
        int          n;
        bit          busy_ok;
        bit          hold_ok;
        exp_r   = ref_div(op, a, b);
        exp_lat = ref_lat(op, a, b);
        div_op   = op;
        operand1 = a;
        operand2 = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        operand1 = $urandom;
        operand2 = $urandom;
        div_op   = 2'($urandom);
        chk("acc_busy", 32'(busy), 32'd1);
        chk("done_pulse", 32'(done), 32'd0);
        n = 1;
        busy_ok = 1;
        hold_ok = 1;
        while (!done && n < 100) begin
            if (!busy) busy_ok = 0;
            if (result !== prev_result) hold_ok = 0;
            if (glitch && n == 4) begin
                start    = 1'b1;
                operand1 = $urandom;
                operand2 = $urandom;
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        chk("busy_high", 32'(busy_ok), 32'd1);
        chk("result_hold", 32'(hold_ok), 32'd1);
        chk("latency", 32'(n), 32'(exp_lat));
        chk("result", result, exp_r);
        chk("busy_at_done", 32'(busy), 32'd0);
        prev_result = exp_r;
    endtask

    task automatic no_done_for(input string tag, input int cycles);
        bit seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    function automatic logic [31:0] pick_a();
        case ($urandom_range(0, 4))
            0: return 32'h8000_0000;
            1: return 32'($urandom_range(0, 200));
            2: return 32'd0 - 32'($urandom_range(1, 200));
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [31:0] pick_b();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'd1;
            3: return 32'($urandom_range(1, 20));
            4: return 32'd0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        checks      = 0;
        failures    = 0;
        prev_result = 32'd0;
        rst      = 1'b1;
        start    = 1'b0;
        kill     = 1'b0;
        div_op   = 2'b00;
        operand1 = 32'd0;
        operand2 = 32'd0;
        #12;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(OP_DIVU, 32'd100, 32'd7, 0);
        run_op(OP_REMU, 32'd100, 32'd7, 0);
        chk("remu_100_7", prev_result, 32'd2);
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(OP_REM, 32'd7, 32'hFFFF_FFFE, 0);
        run_op(OP_DIV, 32'd5, 32'd0, 0);
        run_op(OP_REMU, 32'd5, 32'd0, 0);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd0, 0);
        run_op(OP_REM, 32'hFFFF_FFF9, 32'd0, 0);

        run_op(OP_DIVU, 32'd1000, 32'd7, 1);

        @(posedge clk); #1;
        chk("done_single", 32'(done), 32'd0);

        start  = 1'b1;
        kill   = 1'b1;
        div_op = OP_DIVU;
        operand1 = 32'd50;
        operand2 = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        kill  = 1'b0;
        chk("kill_wins", 32'(busy), 32'd0);

        div_op   = OP_DIVU;
        operand1 = 32'd1000;
        operand2 = 32'd3;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill_idle", 32'(busy), 32'd0);
        no_done_for("kill_nodone", 40);
        chk("kill_result", result, prev_result);
        run_op(OP_DIVU, 32'd9, 32'd3, 0);

        div_op   = OP_DIV;
        operand1 = 32'd12345;
        operand2 = 32'd11;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_result", result, 32'd0);
        prev_result = 32'd0;
        #2;
        rst = 1'b0;
        no_done_for("rst_nodone", 40);
        run_op(OP_REMU, 32'd77, 32'd10, 0);

        for (int i = 0; i < 40; i++)
            run_op(2'($urandom), pick_a(), pick_b(), ($urandom_range(0, 3) == 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL: one clock, reset asynchronous active-high; ports clk, rst.
REQ-002 SHALL: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL: rst  input  1  asynchronous active-high reset.
REQ-004 SHALL: start  input  1  request pulse; accepted only when busy=0 and kill=0.
REQ-005 SHALL: kill  input  1  abort request (pipeline flush).
REQ-006 SHALL: div_op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 SHALL: operand1  input  32  dividend, sampled only on the accepting edge.
REQ-008 SHALL: operand2  input  32  divisor, sampled only on the accepting edge.
REQ-009 SHALL: busy  output  1  high from the edge after acceptance until done.
REQ-010 SHALL: done  output  1  single-cycle completion pulse.
REQ-011 SHALL: result  output  32  quotient or remainder; held stable until the next done.

Function
REQ-012 SHALL: states are IDLE, CALC, FIN. IDLE->CALC on accepted start; CALC->FIN after 32 iterations; FIN->IDLE after one cycle.
REQ-013 SHALL: the accepting edge latches the op, the sign flags, the operand magnitudes (two's-complement absolute value for DIV/REM, raw value for DIVU/REMU) and clears the iteration counter.
REQ-014 SHALL: CALC performs radix-2 restoring division, one quotient bit per cycle, MSB first, on a 33-bit partial remainder with unsigned compare/subtract.
REQ-015 SHALL: the 5-bit iteration counter increments each CALC cycle; CALC exits when the counter wraps from 31.
REQ-016 SHALL: the FIN edge writes result and sets done=1 for exactly one cycle; latency is 34 edges (done rises on the 34th rising edge after the accepting edge), except as given in REQ-028.
REQ-017 SHALL: DIV quotient is negated iff the signs of operand1 and operand2 differ and operand2!=0; REM remainder takes the sign of operand1.
REQ-018 SHALL: divide by zero returns 0xFFFFFFFF for DIV/DIVU and operand1 for REM/REMU.
REQ-019 SHALL: signed overflow (0x80000000 / 0xFFFFFFFF) returns 0x80000000 for DIV and 0x00000000 for REM.
REQ-020 SHALL: start while busy=1 is ignored without side effects.
REQ-021 SHALL: kill in CALC or FIN returns to IDLE on the next edge, suppresses done and leaves result unchanged.
REQ-022 SHALL: kill and start asserted together in IDLE: kill wins and start is not accepted.
REQ-023 SHALL: a new start is accepted in the cycle done is high (the state is IDLE), giving back-to-back operation.

Reset
REQ-024 SHALL: rst=1 forces IDLE, busy=0, done=0, result=0x00000000, counter=0 and partial remainder=0, asynchronously.
REQ-025 SHALL: reset during CALC or FIN aborts the operation; no done pulse follows reset release.
REQ-026 SHALL: the first start after reset deassertion is accepted normally.

Configuration
REQ-027 SHALL: macro DIV_FAST_SPECIAL_EN selects special-case fast completion.
REQ-028 SHALL: with DIV_FAST_SPECIAL_EN defined, divide by zero and signed overflow skip CALC and go IDLE->FIN, so done rises on the 2nd edge after acceptance with the REQ-018/019 values.
REQ-029 SHALL: without DIV_FAST_SPECIAL_EN, all operations take the full 34-edge latency and produce identical result values.

Verification
REQ-030 SHALL: DIVU 100/7 and REMU 100/7 -> result 14 and 2, done on the 34th edge, busy high for the intervening cycles.
REQ-031 SHALL: DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); REM 7/-2 -> 1.
REQ-032 SHALL: DIV 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000; done on edge 2 with the macro and edge 34 without.
REQ-033 SHALL: kill asserted on the 10th CALC cycle -> no done, result keeps its previous value, and the next start (DIVU 9/3) gives 3.
REQ-034 SHALL: rst asserted mid-CALC -> busy=0 and result=0 immediately; start pulsed while busy -> ignored, first result unaffected.
